// File: rtl/pmem_arbiter_pkg.sv
// Shared types and widths for the physical-memory port arbiter.
package pmem_arb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned MASK_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    REQ_IFU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

endpackage

// File: rtl/pmem_arbiter_rr_picker.sv
// Grant selection between IFU and LSU; remembers the last winner for round-robin.
module pmem_rr_picker
  import pmem_arb_pkg::*;
#(
  parameter int unsigned ARB_MODE = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en_i,
  input  logic       ifu_valid_i,
  input  logic       lsu_valid_i,
  output logic [1:0] grant_o
);

  req_e       last_q, last_d;
  logic [1:0] grant_s;

  // Bit 0 grants the IFU, bit 1 the LSU; ties go to LSU or to whoever lost last.
  always_comb begin
    grant_s = 2'b00;
    if (!en_i) begin
      grant_s = 2'b00;
    end else if (ifu_valid_i && lsu_valid_i) begin
      if (ARB_MODE == 32'd0) begin
        grant_s = 2'b10;
      end else if (last_q == REQ_LSU) begin
        grant_s = 2'b01;
      end else begin
        grant_s = 2'b10;
      end
    end else begin
      grant_s = {lsu_valid_i, ifu_valid_i};
    end
  end

  always_comb begin
    last_d = last_q;
    if (grant_s[1]) begin
      last_d = REQ_LSU;
    end else if (grant_s[0]) begin
      last_d = REQ_IFU;
    end else begin
      last_d = last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_q <= REQ_LSU;
    end else begin
      last_q <= last_d;
    end
  end

  assign grant_o = grant_s;

endmodule

// File: rtl/pmem_arbiter.sv
// Shares the single physical-memory port between instruction fetch and load/store.
// One transaction in flight at a time; ACCESS lasts LATENCY cycles to emulate slow memory.
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int unsigned LATENCY  = 1,
  parameter int unsigned ARB_MODE = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [XLEN-1:0]   ifu_raddr,
  output logic              ifu_resp_valid,
  input  logic              ifu_resp_ready,
  output logic [XLEN-1:0]   ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_wen,
  input  logic [XLEN-1:0]   lsu_addr,
  input  logic [XLEN-1:0]   lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  input  logic              lsu_resp_ready,
  output logic [XLEN-1:0]   lsu_rdata,
  output logic              mem_valid,
  output logic [XLEN-1:0]   mem_raddr,
  output logic              mem_wen,
  output logic [XLEN-1:0]   mem_waddr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 32'd1);

  state_e            state_q, state_d;
  req_e              owner_q, owner_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              wen_q, wen_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic [XLEN-1:0]   ifu_rdata_q, ifu_rdata_d;
  logic [XLEN-1:0]   lsu_rdata_q, lsu_rdata_d;
  logic [1:0]        grant_s;
  logic              pick_en_s;
  logic              issue_s;

  // Grants only in IDLE and never while reset is held, so a handshake always means a real accept.
  assign pick_en_s = resetn && (state_q == IDLE);
  assign issue_s   = resetn && (state_q == ACCESS) && (cnt_q == 4'd0);

  pmem_rr_picker #(.ARB_MODE(ARB_MODE)) u_picker (
    .clk        (clk),
    .resetn     (resetn),
    .en_i       (pick_en_s),
    .ifu_valid_i(ifu_req_valid),
    .lsu_valid_i(lsu_req_valid),
    .grant_o    (grant_s)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      owner_q     <= REQ_IFU;
      cnt_q       <= 4'd0;
      addr_q      <= {XLEN{1'b0}};
      wdata_q     <= {XLEN{1'b0}};
      wen_q       <= 1'b0;
      wmask_q     <= {MASK_W{1'b0}};
      ifu_rdata_q <= {XLEN{1'b0}};
      lsu_rdata_q <= {XLEN{1'b0}};
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wen_q       <= wen_d;
      wmask_q     <= wmask_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wen_d       = wen_q;
    wmask_d     = wmask_q;
    ifu_rdata_d = ifu_rdata_q;
    lsu_rdata_d = lsu_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_s[1]) begin
          state_d = ACCESS;
          owner_d = REQ_LSU;
          cnt_d   = CNT_INIT;
          addr_d  = lsu_addr;
          wen_d   = lsu_wen;
          wdata_d = lsu_wdata;
          wmask_d = lsu_wmask;
        end else if (grant_s[0]) begin
          state_d = ACCESS;
          owner_d = REQ_IFU;
          cnt_d   = CNT_INIT;
          addr_d  = ifu_raddr;
          wen_d   = 1'b0;
          wdata_d = {XLEN{1'b0}};
          wmask_d = {MASK_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (owner_q == REQ_LSU) begin
          state_d     = RESP;
          lsu_rdata_d = wen_q ? {XLEN{1'b0}} : mem_rdata;
        end else begin
          state_d     = RESP;
          ifu_rdata_d = mem_rdata;
        end
      end
      RESP: begin
        if ((owner_q == REQ_IFU) ? ifu_resp_ready : lsu_resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ifu_req_ready  = grant_s[0];
    lsu_req_ready  = grant_s[1];
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    if (resetn && (state_q == RESP)) begin
      ifu_resp_valid = (owner_q == REQ_IFU);
      lsu_resp_valid = (owner_q == REQ_LSU);
    end else begin
      ifu_resp_valid = 1'b0;
      lsu_resp_valid = 1'b0;
    end
    mem_valid = issue_s;
    if (issue_s) begin
      mem_raddr = addr_q;
      mem_waddr = addr_q;
      mem_wen   = wen_q;
      mem_wdata = wdata_q;
      mem_wmask = wmask_q;
    end else begin
      mem_raddr = {XLEN{1'b0}};
      mem_waddr = {XLEN{1'b0}};
      mem_wen   = 1'b0;
      mem_wdata = {XLEN{1'b0}};
      mem_wmask = {MASK_W{1'b0}};
    end
  end

  assign ifu_rdata = ifu_rdata_q;
  assign lsu_rdata = lsu_rdata_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: four instances (LAT1/RR, LAT1/fixed, LAT4/RR, LAT3/RR) share stimulus.
module tb_pmem_arbiter;
  import pmem_arb_pkg::*;

  typedef struct packed {
    logic        ifu_req_ready;
    logic        lsu_req_ready;
    logic        ifu_resp_valid;
    logic        lsu_resp_valid;
    logic [31:0] ifu_rdata;
    logic [31:0] lsu_rdata;
    logic        mem_valid;
    logic [31:0] mem_raddr;
    logic        mem_wen;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
  } out_t;

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        irr;
    logic        lv;
    logic        lw;
    logic [31:0] la;
    logic [31:0] lwd;
    logic [7:0]  lwm;
    logic        lrr;
    out_t        exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, iv, irr, lv, lw, lrr;
  logic [31:0] ia, la, lwd;
  logic [7:0]  lwm;
  out_t        o [4];
  int          errors = 0;
  int          checks = 0;
  vec_t        v [12];
  int          g0 [4];
  int          g1 [4];
  int          n0, n1;

  // Memory model: one fixed instruction word, otherwise an address-derived pattern.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return a ^ 32'h5A5A_5A5A;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned L = (g == 2) ? 4 : ((g == 3) ? 3 : 1);
    localparam int unsigned A = (g == 1) ? 0 : 1;
    logic        irdy, lrdy, irv, lrv, mv, mw;
    logic [31:0] ird, lrd, mra, mwa, mwd, mrd;
    logic [7:0]  mwm;
    assign mrd = mem_fn(mra);
    pmem_arbiter #(.LATENCY(L), .ARB_MODE(A)) u_dut (
      .clk(clk), .resetn(resetn),
      .ifu_req_valid(iv), .ifu_req_ready(irdy), .ifu_raddr(ia),
      .ifu_resp_valid(irv), .ifu_resp_ready(irr), .ifu_rdata(ird),
      .lsu_req_valid(lv), .lsu_req_ready(lrdy), .lsu_wen(lw), .lsu_addr(la),
      .lsu_wdata(lwd), .lsu_wmask(lwm),
      .lsu_resp_valid(lrv), .lsu_resp_ready(lrr), .lsu_rdata(lrd),
      .mem_valid(mv), .mem_raddr(mra), .mem_wen(mw), .mem_waddr(mwa),
      .mem_wdata(mwd), .mem_wmask(mwm), .mem_rdata(mrd)
    );
    assign o[g] = {irdy, lrdy, irv, lrv, ird, lrd, mv, mra, mw, mwa, mwd, mwm};
  end

  function automatic out_t e(input logic a, b, c, d, input logic [31:0] ird, lrd,
                             input logic mv, input logic [31:0] ma, input logic mw,
                             input logic [31:0] wd, input logic [7:0] wm);
    return {a, b, c, d, ird, lrd, mv, ma, mw, ma, wd, wm};
  endfunction

  function automatic vec_t mkv(input logic iv_, input logic [31:0] ia_, input logic lv_, lw_,
                               input logic [31:0] la_, lwd_, input logic [7:0] lwm_, input out_t x);
    vec_t r;
    r.iv = iv_; r.ia = ia_; r.irr = 1'b1;
    r.lv = lv_; r.lw = lw_; r.la = la_; r.lwd = lwd_; r.lwm = lwm_; r.lrr = 1'b1;
    r.exp = x;
    return r;
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0; iv = 1'b0; ia = 32'h0; irr = 1'b0; lv = 1'b0; lw = 1'b0;
    la = 32'h0; lwd = 32'h0; lwm = 8'h0; lrr = 1'b0;
    nxt(); nxt();
    resetn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset: readies stay low even with valids high, and everything is zero afterwards.
    do_reset();
    resetn = 1'b0; iv = 1'b1; lv = 1'b1;
    nxt();
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk("reset_held", o[i], '0);
    nxt();
    resetn = 1'b1; iv = 1'b0; lv = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk("reset_idle", o[i], '0);
    do_reset();

    // LATENCY=1: IFU read, LSU write, LSU read, cycle by cycle on instance 0.
    v[0]  = mkv(1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00,
                e(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00));
    v[1]  = mkv(1'b0, 32'hFFFF_0000, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00,
                e(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h8000_0000, 1'b0, 32'h0, 8'h00));
    v[2]  = mkv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00,
                e(1'b0, 1'b0, 1'b1, 1'b0, 32'h413, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00));
    v[3]  = mkv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00,
                e(1'b0, 1'b0, 1'b0, 1'b0, 32'h413, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00));
    v[4]  = mkv(1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 8'h0F,
                e(1'b0, 1'b1, 1'b0, 1'b0, 32'h413, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00));
    v[5]  = mkv(1'b0, 32'h0, 1'b0, 1'b0, 32'h1234_5678, 32'h0, 8'hFF,
                e(1'b0, 1'b0, 1'b0, 1'b0, 32'h413, 32'h0, 1'b1, 32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 8'h0F));
    v[6]  = mkv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00,
                e(1'b0, 1'b0, 1'b0, 1'b1, 32'h413, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00));
    v[7]  = mkv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00,
                e(1'b0, 1'b0, 1'b0, 1'b0, 32'h413, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00));
    v[8]  = mkv(1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0200, 32'h1111_1111, 8'h03,
                e(1'b0, 1'b1, 1'b0, 1'b0, 32'h413, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00));
    v[9]  = mkv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00,
                e(1'b0, 1'b0, 1'b0, 1'b0, 32'h413, 32'h0, 1'b1, 32'h8000_0200, 1'b0, 32'h1111_1111, 8'h03));
    v[10] = mkv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00,
                e(1'b0, 1'b0, 1'b0, 1'b1, 32'h413, 32'hDA5A_585A, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00));
    v[11] = mkv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00,
                e(1'b0, 1'b0, 1'b0, 1'b0, 32'h413, 32'hDA5A_585A, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00));
    for (int i = 0; i < 12; i++) begin
      iv = v[i].iv; ia = v[i].ia; irr = v[i].irr; lv = v[i].lv; lw = v[i].lw;
      la = v[i].la; lwd = v[i].lwd; lwm = v[i].lwm; lrr = v[i].lrr;
      @(negedge clk);
      chk($sformatf("vec%0d", i), o[0], v[i].exp);
      nxt();
    end

    // Both requesters valid continuously: RR alternates from IFU, fixed priority always LSU.
    do_reset();
    iv = 1'b1; lv = 1'b1; irr = 1'b1; lrr = 1'b1; ia = 32'h8000_0010; la = 32'h8000_0020;
    n0 = 0; n1 = 0;
    for (int c = 0; c < 40 && (n0 < 4 || n1 < 4); c++) begin
      @(negedge clk);
      if (n0 < 4 && (o[0].ifu_req_ready || o[0].lsu_req_ready)) begin
        chk("rr_onehot", {191'd0, o[0].ifu_req_ready & o[0].lsu_req_ready}, 192'd0);
        g0[n0] = o[0].lsu_req_ready ? 1 : 0;
        n0++;
      end
      if (n1 < 4 && (o[1].ifu_req_ready || o[1].lsu_req_ready)) begin
        chk("fp_onehot", {191'd0, o[1].ifu_req_ready & o[1].lsu_req_ready}, 192'd0);
        g1[n1] = o[1].lsu_req_ready ? 1 : 0;
        n1++;
      end
      nxt();
    end
    chk("rr_grants", n0, 4);
    chk("fp_grants", n1, 4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_order", g0[i], i % 2);
      chk("fp_order", g1[i], 1);
    end

    // LATENCY=4 LSU read with three cycles of response backpressure; IFU waits meanwhile.
    do_reset();
    lv = 1'b1; lw = 1'b0; la = 32'h8000_0300; lrr = 1'b0;
    @(negedge clk);
    chk("lat4_accept", o[2].lsu_req_ready, 1);
    nxt();
    lv = 1'b0; iv = 1'b1; ia = 32'h8000_0000; la = 32'hFFFF_FFFF;
    for (int k = 1; k <= 9; k++) begin
      lrr = (k >= 8);
      @(negedge clk);
      chk("lat4_ready", {o[2].ifu_req_ready, o[2].lsu_req_ready}, (k == 9) ? 2'b10 : 2'b00);
      chk("lat4_mem", {o[2].mem_valid, o[2].mem_raddr}, (k == 4) ? {1'b1, 32'h8000_0300} : 33'd0);
      chk("lat4_resp", {o[2].lsu_resp_valid, o[2].lsu_rdata},
          (k >= 5 && k <= 8) ? {1'b1, 32'hDA5A_595A} : ((k == 9) ? {1'b0, 32'hDA5A_595A} : 33'd0));
      nxt();
    end

    // Write accepted, reset asserted next cycle: LAT1 write at cnt==0 and LAT3 write both dropped.
    do_reset();
    lv = 1'b1; lw = 1'b1; la = 32'h8000_0400; lwd = 32'hCAFE_F00D; lwm = 8'h0F; lrr = 1'b1;
    @(negedge clk);
    chk("rst_accept_lat1", o[0].lsu_req_ready, 1);
    chk("rst_accept_lat3", o[3].lsu_req_ready, 1);
    nxt();
    lv = 1'b0; resetn = 1'b0;
    @(negedge clk);
    chk("rst_nowrite_lat1", o[0], '0);
    chk("rst_nowrite_lat3", o[3], '0);
    nxt();
    resetn = 1'b1;
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      chk("rst_quiet_lat1", o[0], '0);
      chk("rst_quiet_lat3", o[3], '0);
      nxt();
    end
    iv = 1'b1; ia = 32'h8000_0000; irr = 1'b1;
    @(negedge clk);
    chk("post_rst_accept", o[3].ifu_req_ready, 1);
    nxt();
    iv = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("post_rst_mem", {o[3].mem_valid, o[3].mem_raddr}, (k == 3) ? {1'b1, 32'h8000_0000} : 33'd0);
      chk("post_rst_resp", {o[3].ifu_resp_valid, o[3].ifu_rdata}, (k == 4) ? {1'b1, 32'h0000_0413} : 33'd0);
      nxt();
    end

    // IFU response backpressure holds off a waiting LSU until the handshake completes.
    do_reset();
    iv = 1'b1; ia = 32'h8000_0500; irr = 1'b0;
    @(negedge clk);
    chk("bp_accept", o[0].ifu_req_ready, 1);
    nxt();
    iv = 1'b0; lv = 1'b1; lw = 1'b0; la = 32'h8000_0600; lrr = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      irr = (k == 4);
      @(negedge clk);
      chk("bp_lsu_ready", o[0].lsu_req_ready, (k == 5) ? 1 : 0);
      chk("bp_ifu_resp", {o[0].ifu_resp_valid, o[0].ifu_rdata},
          (k >= 2 && k <= 4) ? {1'b1, 32'hDA5A_5F5A} : ((k == 5) ? {1'b0, 32'hDA5A_5F5A} : 33'd0));
      nxt();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single DPI-backed physical-memory port (RAM model: valid, raddr, wen, waddr, wdata, wmask, combinational rdata) between two requesters: instruction fetch (IFU, read-only) and load/store unit (LSU, read/write).
- Each requester has a valid/ready request channel and a valid/ready response channel.
- One transaction is in flight at a time, with a configurable access latency that emulates a slow memory.
- Sits between the core pipeline and the memory model at the top of the simulation SoC.

Parameters:
- LATENCY, 1: cycles spent in ACCESS per transaction; legal range 1..15.
- ARB_MODE, 1: 0 = fixed priority (LSU wins ties); 1 = round-robin.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_raddr  in  32  IFU read address
- ifu_resp_valid  out  1  IFU read data valid
- ifu_resp_ready  in  1  IFU takes response
- ifu_rdata  out  32  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted
- lsu_wen  in  1  1 = write, 0 = read
- lsu_addr  in  32  LSU address
- lsu_wdata  in  32  write data
- lsu_wmask  in  8  byte mask; bits [3:0] used
- lsu_resp_valid  out  1  LSU read data / write ack valid
- lsu_resp_ready  in  1  LSU takes response
- lsu_rdata  out  32  LSU read data; 0 for write acks
- mem_valid  out  1  memory access strobe
- mem_raddr  out  32  memory read address
- mem_wen  out  1  memory write enable
- mem_waddr  out  32  memory write address
- mem_wdata  out  32  memory write data
- mem_wmask  out  8  memory write mask
- mem_rdata  in  32  memory read data, combinational from mem_raddr

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- Reset values: all *_ready 0, all *_resp_valid 0, rdata registers 0, cnt 0, owner = IFU, last_grant = LSU (round-robin therefore favours IFU on the first tie).
- All mem_* outputs are 0 whenever resetn is 0 or the state is not ACCESS with cnt==0.
- IDLE:
  - ifu_req_ready / lsu_req_ready are combinational from the valids; at most one is ever high; both are 0 outside IDLE.
  - Grant rules:
    - Only one valid: that requester is granted.
    - Both valid, ARB_MODE=0: LSU is granted.
    - Both valid, ARB_MODE=1: the requester not equal to last_grant is granted.
  - On a handshake: latch owner, address, wen (0 for IFU), wdata and wmask (0 for IFU); update last_grant; set cnt = LATENCY-1; go to ACCESS.
- ACCESS:
  - While cnt != 0: decrement cnt; mem_valid = 0.
  - When cnt == 0 (exactly one cycle):
    - mem_valid = 1; mem_raddr = mem_waddr = latched address; mem_wen = latched wen; mem_wdata / mem_wmask = latched values.
    - Capture mem_rdata into the owner's rdata register. Writes capture 0.
    - Go to RESP.
  - The memory write commits on the edge that leaves ACCESS.
  - Exactly one mem_valid cycle occurs per transaction.
- RESP:
  - The owner's resp_valid is 1 and its rdata is stable until its resp_ready = 1. The handshake edge returns the FSM to IDLE.
  - The non-owner's resp_valid is 0.
  - A new request cannot be accepted in the same cycle as a response handshake.
- Timing:
  - Request handshake in cycle T gives mem_valid in cycle T+LATENCY and resp_valid in cycle T+LATENCY+1.
  - Minimum issue interval is LATENCY+2 cycles.
- Request-side inputs may change after acceptance without effect.
- Reset mid-operation:
  - resetn low in any state returns the FSM to IDLE on the next edge and drops resp_valid.
  - A write in ACCESS with cnt==0 while resetn is low is not issued.
  - The pending response is discarded.
- Address alignment is not checked. Addresses are passed through unmodified.

Decomposition:
- Package pmem_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}
  - requester enum {REQ_IFU, REQ_LSU}
  - constants XLEN=32 and MASK_W=8
- One sub-module, pmem_rr_picker:
  - Inputs: the two valids, ARB_MODE, an enable (from IDLE), clk and resetn.
  - Outputs: a one-hot grant.
  - Holds the last_grant register and updates it on the accepting handshake.

Test Plan:
- LATENCY=1. IFU read of 0x8000_0000, memory returns 0x0000_0413, ifu_resp_ready held 1 → ifu_req_ready in cycle 0, mem_valid only in cycle 1, ifu_resp_valid in cycle 2 with ifu_rdata = 0x0000_0413, back to IDLE in cycle 3.
- LSU write: addr 0x8000_0100, wdata 0xDEAD_BEEF, wmask 0x0F → exactly one mem_valid cycle with mem_wen=1, mem_waddr=0x8000_0100, mem_wmask=0x0F; lsu_resp_valid with lsu_rdata = 0; no IFU response.
- ARB_MODE=1, both requesters valid continuously for 4 transactions → grant order IFU, LSU, IFU, LSU. ARB_MODE=0 with the same stimulus → LSU, LSU, LSU, LSU.
- LATENCY=4, LSU read, lsu_resp_ready low for 3 cycles → mem_valid in cycle T+4, lsu_resp_valid from T+5 held for 3 cycles with stable data, no new grant until the FSM returns to IDLE.
- LATENCY=3, LSU write accepted, resetn driven low in cycle T+1 → mem_valid never asserted, all outputs at reset values from T+2, a new IFU request after reset is served normally.
- Response backpressure on the IFU while lsu_req_valid is high → lsu_req_ready stays 0 until the IFU response handshake completes; the LSU is granted in the next IDLE cycle.
